// File: rtl/quad_encoder_emulator.sv
// rtl/quad_encoder_emulator.sv - synthetic quadrature A/B generator with windowed rate control
`timescale 1ns/1ps
module quad_encoder_emulator #(
  parameter int WINDOW_CLKS = 2000000,
  parameter int CNT_W       = 8,
  parameter int ACC_W       = 22
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CNT_W-1:0] rate_in,
  input  logic             dir_in,
  input  logic             rate_load,
  output logic             signalA,
  output logic             signalB,
  output logic             window_start,
  output logic [CNT_W-1:0] rate_active,
  output logic [CNT_W-1:0] edges_emitted
);

  localparam int WIN_W = (WINDOW_CLKS > 1) ? $clog2(WINDOW_CLKS) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CLKS - 1);
  localparam logic [ACC_W:0]   WIN_SUM  = (ACC_W + 1)'(WINDOW_CLKS);

  logic             run_q, run_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] rate_active_q, rate_active_d;
  logic             dir_active_q, dir_active_d;
  logic [CNT_W-1:0] pending_rate_q, pending_rate_d;
  logic             pending_dir_q, pending_dir_d;
  logic [CNT_W-1:0] a_fall_cnt_q, a_fall_cnt_d;
  logic [CNT_W-1:0] edges_emitted_q, edges_emitted_d;
  logic             window_start_q, window_start_d;

  logic             boundary;
  logic             step;
  logic             a_fall;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   sum_wrap;
  logic [1:0]       phase_next;
  logic [CNT_W-1:0] fall_inc;

  always_comb begin
    boundary   = run_q && (win_cnt_q == WIN_LAST);
    sum        = {1'b0, acc_q} + (ACC_W + 1)'({rate_active_q, 2'b00});
    sum_wrap   = sum - WIN_SUM;
    step       = run_q && (sum >= WIN_SUM);
    // Forward walks 00->10->11->01, reverse walks the same ring backwards.
    phase_next = dir_active_q ? {phase_q[0], ~phase_q[1]} : {~phase_q[0], phase_q[1]};
    a_fall     = step && phase_q[1] && !phase_next[1];
    fall_inc   = {{(CNT_W - 1){1'b0}}, a_fall};

    run_d           = 1'b1;
    win_cnt_d       = (!run_q || boundary) ? '0 : win_cnt_q + 1'b1;
    window_start_d  = (win_cnt_d == '0);
    acc_d           = acc_q;
    phase_d         = step ? phase_next : phase_q;
    rate_active_d   = rate_active_q;
    dir_active_d    = dir_active_q;
    pending_rate_d  = pending_rate_q;
    pending_dir_d   = pending_dir_q;
    a_fall_cnt_d    = a_fall_cnt_q + fall_inc;
    edges_emitted_d = edges_emitted_q;

    if (run_q) begin
      acc_d = step ? sum_wrap[ACC_W-1:0] : sum[ACC_W-1:0];
    end

    if (rate_load) begin
      pending_rate_d = rate_in;
      pending_dir_d  = dir_in;
    end

    // A load landing on the boundary itself is applied without waiting a window.
    if (boundary) begin
      acc_d           = '0;
      rate_active_d   = rate_load ? rate_in : pending_rate_q;
      dir_active_d    = rate_load ? dir_in  : pending_dir_q;
      edges_emitted_d = a_fall_cnt_q + fall_inc;
      a_fall_cnt_d    = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q           <= 1'b0;
      win_cnt_q       <= '0;
      acc_q           <= '0;
      phase_q         <= 2'b00;
      rate_active_q   <= '0;
      dir_active_q    <= 1'b0;
      pending_rate_q  <= '0;
      pending_dir_q   <= 1'b0;
      a_fall_cnt_q    <= '0;
      edges_emitted_q <= '0;
      window_start_q  <= 1'b0;
    end else begin
      run_q           <= run_d;
      win_cnt_q       <= win_cnt_d;
      acc_q           <= acc_d;
      phase_q         <= phase_d;
      rate_active_q   <= rate_active_d;
      dir_active_q    <= dir_active_d;
      pending_rate_q  <= pending_rate_d;
      pending_dir_q   <= pending_dir_d;
      a_fall_cnt_q    <= a_fall_cnt_d;
      edges_emitted_q <= edges_emitted_d;
      window_start_q  <= window_start_d;
    end
  end

  assign signalA       = phase_q[1];
  assign signalB       = phase_q[0];
  assign window_start  = window_start_q;
  assign rate_active   = rate_active_q;
  assign edges_emitted = edges_emitted_q;

endmodule
